clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Runtime controller for the clock-divider datapath of the tt_um_* tile. One
//  free-running counter generates a divided square wave and a period tick for a
//  ratio selected at runtime. Ratio changes and stop requests take effect only
//  at a period boundary, so no runt high/low phase ever reaches the output pins.
//  All logic is synchronous to clk. Divided signals are data/enables, never clocks.
// PARAMETERS
//  CNT_W    5  counter width; ratios 2^1..2^CNT_W
//  SEL_W    3  width of ratio select (must satisfy 2^SEL_W >= CNT_W)
//  DEF_SEL  0  ratio select loaded at reset (0 => /2)
// PORTS
//  clk         in   1      single clock
//  rst_n       in   1      synchronous reset, active low
//  ena         in   1      run request; 1 = count, 0 = stop at period end
//  cfg_sel     in   SEL_W  requested ratio: N = 2^(cfg_sel+1)
//  cfg_valid   in   1      cfg_sel valid
//  cfg_ready   out  1      controller can accept cfg_sel
//  div_out     out  1      divided square wave, 50% duty
//  tick        out  1      1-cycle pulse in the last cycle of each period
//  active_sel  out  SEL_W  ratio select currently in force
//  busy        out  1      1 in RUN/DRAIN/STOP
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge, any state): state=IDLE, cnt=0, active_sel=DEF_SEL,
//   pend_sel=DEF_SEL, div_out=0, tick=0, busy=0, cfg_ready=1. Mid-run reset aborts at once.
//  Clamp: any cfg_sel > CNT_W-1 is stored as CNT_W-1.
//  Outputs decode registers only; no combinational input->output path:
//   div_out = cnt[active_sel] & busy
//   tick = busy & (cnt[active_sel:0] all ones)
//  Handshake: accept occurs when cfg_valid & cfg_ready at a clk edge; value goes to
//   pend_sel. cfg_valid may stay high while cfg_ready=0 without effect.
//  IDLE: cnt held at 0. cfg_ready=1. An accept loads active_sel directly.
//   Goes to RUN when ena=1.
//  RUN: cnt+1 each cycle, wrapping at 2^CNT_W. cfg_ready=1.
//   An accept moves to DRAIN. ena=0 moves to STOP.
//   If both happen in the same cycle, the accept wins (DRAIN), and ena is re-sampled at the boundary.
//  DRAIN: cfg_ready=0, counting continues. In the tick cycle: active_sel<=pend_sel, cnt<=0.
//   Next state is RUN if ena=1, otherwise IDLE.
//   The new ratio takes effect on the first cycle after the tick.
//   Re-selecting the same ratio still drains, which is harmless.
//  STOP: cfg_ready=0, counting continues. In the tick cycle: cnt<=0 and go to IDLE.
//   ena reasserted in STOP does not cancel the stop; IDLE restarts next cycle.
//  Latency: IDLE->RUN with ena=1 at edge k gives cnt=1 after edge k+1.
//   The first div_out high occurs N/2 cycles after RUN is entered.
//  Boundaries: cnt wrap is a natural period end when active_sel=CNT_W-1.
//   A request arriving in the tick cycle while in RUN drains one full extra period, by design.
// STRUCTURE
//  Package clk_div_ctrl_pkg holds:
//   state_t enum {IDLE, RUN, DRAIN, STOP} (2-bit)
//   SEL_DIV2..SEL_DIV32 constants
//   function clamp_sel()
//  Sub-module clk_div_tap (cnt, sel -> div_out, tick) contains the tap mux and the all-ones detect.
//  The FSM and counter stay in clk_div_ctrl.
// TESTING
//  1 Reset, ena=1, DEF_SEL=0: div_out toggles every cycle; tick every 2nd cycle; busy=1.
//  2 In RUN at /2, accept cfg_sel=2: cfg_ready=0 until the next tick.
//    Then active_sel=2, div_out is 4 high / 4 low, tick every 8 cycles. No phase is shorter than 1 cycle.
//  3 cfg_sel=7 (CNT_W=5): active_sel=4, period 32, tick once every 32 cycles.
//  4 At /8, drop ena at cnt=2: busy stays high until the tick (cnt=7), then IDLE.
//    div_out=0 and cnt=0 afterwards.
//  5 Assert rst_n=0 for 1 cycle mid-DRAIN: all outputs return to reset values.
//    pend_sel is discarded. After that, run at /2.
//  6 Apply cfg_valid and ena fall in the same cycle while in RUN at /4 -> DRAIN.
//    At the tick the new sel loads and the state goes to IDLE. cfg_ready=1 afterwards.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the runtime clock-divider controller.
// Ratio select s means divide by 2^(s+1).
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned SEL_DIV2  = 0;
  localparam int unsigned SEL_DIV4  = 1;
  localparam int unsigned SEL_DIV8  = 2;
  localparam int unsigned SEL_DIV16 = 3;
  localparam int unsigned SEL_DIV32 = 4;

  function automatic int unsigned clamp_sel(
    input int unsigned sel,
    input int unsigned max_sel
  );
    return (sel > max_sel) ? max_sel : sel;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio-select valid/ready handshake between a requester and the
// divider controller.
interface clk_div_ctrl_if #(
  parameter int SEL_W = 3
);
  logic [SEL_W-1:0] cfg_sel;
  logic             cfg_valid;
  logic             cfg_ready;

  modport master (
    output cfg_sel,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_sel,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_tap.sv
// Tap mux and period-end detect for the free-running divider counter.
// Only cnt[sel:0] matter, so the counter may free-run above the tap.
module clk_div_tap #(
  parameter int CNT_W = 5,
  parameter int SEL_W = 3
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic             div_out,
  output logic             tick
);
  logic [CNT_W-1:0] mask;
  logic [CNT_W-1:0] hot;

  always_comb begin
    mask = '0;
    hot  = '0;
    for (int i = 0; i < CNT_W; i++) begin
      mask[i] = (SEL_W'(i) <= sel);
      hot[i]  = (SEL_W'(i) == sel);
    end
  end

  assign div_out = en & (|(cnt & hot));
  assign tick    = en & ((cnt & mask) == mask);
endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime divider controller: ratio changes and stops are deferred to
// the period-end tick so the output never shows a runt phase.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int CNT_W   = 5,
  parameter int SEL_W   = 3,
  parameter int DEF_SEL = SEL_DIV2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  clk_div_ctrl_if.slave    cfg,
  output logic             div_out,
  output logic             tick,
  output logic [SEL_W-1:0] active_sel,
  output logic             busy
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] pend_sel;
  logic [SEL_W-1:0] sel_c;
  logic             accept;

  assign sel_c = SEL_W'(clamp_sel(32'(cfg.cfg_sel),
                                  32'(CNT_W - 1)));

  assign busy          = (state != IDLE);
  assign cfg.cfg_ready = (state == IDLE) | (state == RUN);
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  clk_div_tap #(
    .CNT_W (CNT_W),
    .SEL_W (SEL_W)
  ) u_tap (
    .cnt     (cnt),
    .sel     (active_sel),
    .en      (busy),
    .div_out (div_out),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      active_sel <= SEL_W'(DEF_SEL);
      pend_sel   <= SEL_W'(DEF_SEL);
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            active_sel <= sel_c;
            pend_sel   <= sel_c;
          end
          if (ena) state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (accept) begin
            pend_sel <= sel_c;
            state    <= DRAIN;
          end else if (!ena) begin
            state <= STOP;
          end
        end
        DRAIN: begin
          if (tick) begin
            cnt        <= '0;
            active_sel <= pend_sel;
            state      <= ena ? RUN : IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random
// traffic against a period-position reference model.
module tb_clk_div_ctrl;
  import clk_div_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       div_out;
  logic       tick;
  logic [2:0] active_sel;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_ctrl_if #(.SEL_W(3)) cfg_if ();

  clk_div_ctrl #(
    .CNT_W   (5),
    .SEL_W   (3),
    .DEF_SEL (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cfg        (cfg_if.slave),
    .div_out    (div_out),
    .tick       (tick),
    .active_sel (active_sel),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Model: running flag, position within the current period, ratio,
  // pending ratio (-1 = none) and pending stop.
  int m_run  = 0;
  int m_pos  = 0;
  int m_sel  = 0;
  int m_pend = -1;
  int m_stop = 0;

  function automatic logic m_ready();
    return (m_run == 0) || (m_pend < 0 && m_stop == 0);
  endfunction

  function automatic logic [6:0] m_vec();
    int n;
    n = 2 << m_sel;
    return {(m_run != 0),
            (m_run != 0 && m_pos == n - 1),
            (m_run != 0 && m_pos >= n / 2),
            m_ready(),
            3'(m_sel)};
  endfunction

  function automatic logic [6:0] obs();
    return {busy, tick, div_out, cfg_if.cfg_ready, active_sel};
  endfunction

  task automatic step(input logic r, input logic e,
                      input logic v, input logic [2:0] s);
    logic rdy;
    int   n;
    int   c;
    rst_n = r;
    ena   = e;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_sel   = s;
    rdy = m_ready();
    @(posedge clk);
    n = 2 << m_sel;
    c = (s > 3'd4) ? 4 : int'(s);
    if (!r) begin
      m_run = 0; m_pos = 0; m_sel = 0; m_pend = -1; m_stop = 0;
    end else if (m_run == 0) begin
      if (v && rdy) m_sel = c;
      m_run = e ? 1 : 0;
      m_pos = 0;
    end else if (m_pend >= 0 || m_stop != 0) begin
      if (m_pos == n - 1) begin
        m_run = (m_pend >= 0 && e) ? 1 : 0;
        if (m_pend >= 0) m_sel = m_pend;
        m_pend = -1;
        m_stop = 0;
        m_pos  = 0;
      end else begin
        m_pos++;
      end
    end else begin
      m_pos = (m_pos + 1) % n;
      if (v && rdy) m_pend = c;
      else if (!e) m_stop = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 3'd0);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b exp 0", busy);
    end
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b exp 1", cfg_if.cfg_ready);
    end
    n_tests++;
    if (active_sel !== 3'(SEL_DIV2)) begin
      n_fail++; $display("FAIL reset_sel: got %0d exp 0", active_sel);
    end
    n_tests++;
    if ({div_out, tick} !== 2'b00) begin
      n_fail++; $display("FAIL reset_out: got %b exp 00", {div_out, tick});
    end
  endtask

  task automatic test_div2();
    int toggles;
    logic prev;
    toggles = 0;
    step(1'b1, 1'b1, 1'b0, 3'd0);
    prev = div_out;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'd0);
      if (div_out !== prev) toggles++;
      prev = div_out;
      n_tests++;
      if (obs() !== m_vec()) begin
        n_fail++; $display("FAIL div2 c%0d: got %b exp %b", i, obs(), m_vec());
      end
    end
    n_tests++;
    if (toggles != 10) begin
      n_fail++; $display("FAIL div2_toggles: got %0d exp 10", toggles);
    end
  endtask

  task automatic test_drain();
    step(1'b1, 1'b1, 1'b1, 3'(SEL_DIV8));
    for (int i = 0; i < 24; i++) begin
      n_tests++;
      if (obs() !== m_vec()) begin
        n_fail++; $display("FAIL drain c%0d: got %b exp %b", i, obs(), m_vec());
      end
      step(1'b1, 1'b1, 1'b0, 3'd0);
    end
    n_tests++;
    if (active_sel !== 3'd2) begin
      n_fail++; $display("FAIL drain_sel: got %0d exp 2", active_sel);
    end
  endtask

  task automatic test_clamp();
    int ticks;
    ticks = 0;
    step(1'b1, 1'b1, 1'b1, 3'd7);
    for (int i = 0; i < 100 && m_pend >= 0; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'd0);
      n_tests++;
      if (obs() !== m_vec()) begin
        n_fail++; $display("FAIL clamp_d c%0d: got %b exp %b", i, obs(), m_vec());
      end
    end
    n_tests++;
    if (active_sel !== 3'(SEL_DIV32)) begin
      n_fail++; $display("FAIL clamp_sel: got %0d exp 4", active_sel);
    end
    for (int i = 0; i < 64; i++) begin
      if (tick) ticks++;
      n_tests++;
      if (obs() !== m_vec()) begin
        n_fail++; $display("FAIL clamp c%0d: got %b exp %b", i, obs(), m_vec());
      end
      step(1'b1, 1'b1, 1'b0, 3'd0);
    end
    n_tests++;
    if (ticks != 2) begin
      n_fail++; $display("FAIL clamp_ticks: got %0d exp 2", ticks);
    end
  endtask

  task automatic test_stop();
    step(1'b1, 1'b1, 1'b1, 3'(SEL_DIV8));
    for (int i = 0; i < 100 && (m_pend >= 0 || m_pos != 2); i++)
      step(1'b1, 1'b1, 1'b0, 3'd0);
    n_tests++;
    if (m_pos != 2 || active_sel !== 3'd2) begin
      n_fail++; $display("FAIL stop_setup: got pos %0d sel %0d exp 2", m_pos, active_sel);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 3'd0);
      n_tests++;
      if (obs() !== m_vec()) begin
        n_fail++; $display("FAIL stop c%0d: got %b exp %b", i, obs(), m_vec());
      end
    end
    n_tests++;
    if ({busy, div_out} !== 2'b00) begin
      n_fail++; $display("FAIL stop_idle: got %b exp 00", {busy, div_out});
    end
  endtask

  task automatic test_reset_drain();
    step(1'b1, 1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b1, 1'b1, 3'(SEL_DIV16));
    step(1'b1, 1'b1, 1'b0, 3'd0);
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstd_drain: got %b exp 0", cfg_if.cfg_ready);
    end
    step(1'b0, 1'b1, 1'b0, 3'd0);
    n_tests++;
    if (obs() !== 7'b0001000) begin
      n_fail++; $display("FAIL rstd_reset: got %b exp 0001000", obs());
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'd0);
      n_tests++;
      if (obs() !== m_vec()) begin
        n_fail++; $display("FAIL rstd c%0d: got %b exp %b", i, obs(), m_vec());
      end
    end
  endtask

  task automatic test_accept_and_stop();
    step(1'b1, 1'b1, 1'b1, 3'(SEL_DIV4));
    for (int i = 0; i < 100 && m_pend >= 0; i++)
      step(1'b1, 1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b1, 3'd3);
    for (int i = 0; i < 100 && m_run != 0; i++) begin
      n_tests++;
      if (obs() !== m_vec()) begin
        n_fail++; $display("FAIL accstop c%0d: got %b exp %b", i, obs(), m_vec());
      end
      step(1'b1, 1'b0, 1'b0, 3'd0);
    end
    n_tests++;
    if ({busy, cfg_if.cfg_ready, active_sel} !== 5'b01011) begin
      n_fail++; $display("FAIL accstop_end: got %b exp 01011",
                         {busy, cfg_if.cfg_ready, active_sel});
    end
  endtask

  task automatic test_random();
    logic r, e, v;
    logic [2:0] s;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 79) != 0);
      e = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 5) == 0);
      s = 3'($urandom_range(0, 7));
      step(r, e, v, s);
      n_tests++;
      if (obs() !== m_vec()) begin
        n_fail++; $display("FAIL random c%0d: got %b exp %b", i, obs(), m_vec());
      end
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sel   = 3'd0;
    test_reset();
    test_div2();
    test_drain();
    test_clamp();
    test_stop();
    test_reset_drain();
    test_accept_and_stop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
